bisu_stream_sorter: RTL and testbench

Parametrised, streaming successor to the fixed 4-entry bidirectional insertion sort unit. It accepts one W-bit element per cycle over a valid/ready handshake and insertion-sorts each element into a P-entry register array. When the array is full, or when an element marked last is accepted, it streams the block out in ascending or descending order. It sits between the input distributor and the odd-even merge network, and replaces the per-stage reset sequencing with a single reset and explicit handshakes.

---
 rtl/bisu_pkg.sv | 13 +
 rtl/bisu_cell.sv | 53 +++++
 rtl/bisu_stream_sorter.sv | 120 ++++++++++++
 tb/tb_bisu_stream_sorter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bisu_pkg.sv
// Shared types and helpers for the streaming insertion sorter.
package bisu_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic int count_width(input int p);
    return $clog2(p + 1);
  endfunction

endpackage

// File: rtl/bisu_cell.sv
// One sorter entry: keeps its value, takes the incoming element, or shifts
// up from its lower neighbour so the array stays ascending.
module bisu_cell #(
  parameter int W     = 6,
  parameter bit FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ins,
  input  logic         clr,
  input  logic [W-1:0] in_data,
  input  logic [W-1:0] prev_val,
  input  logic         prev_vld,
  output logic [W-1:0] val_q,
  output logic         vld_q
);

  logic [W-1:0] val_d;
  logic         vld_d;
  logic         keep;
  logic         take;

  // Keeping on equality makes a new element land after existing equals.
  assign keep = vld_q && (val_q <= in_data);
  assign take = FIRST || (prev_vld && (prev_val <= in_data));

  always_comb begin
    val_d = val_q;
    vld_d = vld_q;
    if (clr) begin
      vld_d = 1'b0;
    end else if (ins && !keep) begin
      if (take) begin
        val_d = in_data;
        vld_d = 1'b1;
      end else begin
        val_d = prev_val;
        vld_d = prev_vld;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
      vld_q <= 1'b0;
    end else begin
      val_q <= val_d;
      vld_q <= vld_d;
    end
  end

endmodule

// File: rtl/bisu_stream_sorter.sv
// Streaming insertion sorter: fills a P-entry sorted array over a handshake,
// then drains it ascending or descending.
module bisu_stream_sorter
  import bisu_pkg::*;
#(
  parameter int W  = 6,
  parameter int P  = 4,
  parameter int CW = count_width(P)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  input  logic          inv,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  output logic [CW-1:0] fill_level
);

  localparam logic [CW-1:0] P_CW = CW'(P);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          dir_q, dir_d;

  logic [W-1:0]  ent_val [P];
  logic          ent_vld [P];

  logic          in_acc;
  logic          out_acc;

  assign in_ready   = (state_q == FILL);
  assign out_valid  = (state_q == DRAIN);
  assign in_acc     = in_valid && in_ready;
  assign out_acc    = out_ready && out_valid;
  assign fill_level = count_q;

  for (genvar gi = 0; gi < P; gi++) begin : g_cell
    logic [W-1:0] prev_val;
    logic         prev_vld;
    if (gi == 0) begin : g_head
      assign prev_val = '0;
      assign prev_vld = 1'b0;
    end else begin : g_link
      assign prev_val = ent_val[gi-1];
      assign prev_vld = ent_vld[gi-1];
    end
    bisu_cell #(
      .W     (W),
      .FIRST (gi == 0)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .ins      (in_acc),
      .clr      (out_acc && out_last),
      .in_data  (in_data),
      .prev_val (prev_val),
      .prev_vld (prev_vld),
      .val_q    (ent_val[gi]),
      .vld_q    (ent_vld[gi])
    );
  end

  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    if (state_q == DRAIN) begin
      for (int i = 0; i < P; i++) begin
        if (idx_q == CW'(i)) out_data = ent_val[i];
      end
      out_last = dir_q ? (idx_q == '0) : (idx_q == count_q - 1'b1);
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    if (state_q == FILL) begin
      if (in_acc) begin
        count_d = count_q + 1'b1;
        if (count_q == '0) dir_d = inv;
        if ((count_d == P_CW) || in_last) begin
          state_d = DRAIN;
          // Descending drains start from the largest valid entry.
          idx_d   = dir_d ? (count_d - 1'b1) : '0;
        end
      end
    end else if (out_acc) begin
      if (out_last) begin
        state_d = FILL;
        count_d = '0;
        idx_d   = '0;
      end else begin
        idx_d = dir_q ? (idx_q - 1'b1) : (idx_q + 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      count_q <= '0;
      idx_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
    end
  end

endmodule

// File: tb/tb_bisu_stream_sorter.sv
// Directed bench for bisu_stream_sorter with hand-computed sorted outputs.
module tb_bisu_stream_sorter;

  localparam int W  = 6;
  localparam int P  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          inv = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic [CW-1:0] fill_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bisu_stream_sorter #(.W(W), .P(P)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .inv        (inv),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .fill_level (fill_level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({in_ready, out_valid, out_data, out_last, fill_level} !== {1'b1, 1'b0, 6'd0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_low: rdy=%0b vld=%0b data=%0d last=%0b fill=%0d expected 1 0 0 0 0",
               in_ready, out_valid, out_data, out_last, fill_level);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({in_ready, out_valid, out_data, out_last, fill_level} !== {1'b1, 1'b0, 6'd0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_release: rdy=%0b vld=%0b data=%0d last=%0b fill=%0d expected 1 0 0 0 0",
               in_ready, out_valid, out_data, out_last, fill_level);
    end
    $display("test_reset done");
  endtask

  task automatic test_ascending();
    int v [4] = '{19, 45, 12, 50};
    int e [4] = '{12, 19, 45, 50};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = W'(v[i]);
      inv = 1'b0;
      tick();
      checks++;
      if (fill_level !== CW'(i + 1)) begin
        errors++;
        $display("FAIL asc_fill[%0d]: got %0d expected %0d", i, fill_level, i + 1);
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(e[k]) || out_last !== (k == 3)) begin
        errors++;
        $display("FAIL asc_out[%0d]: vld=%0b data=%0d last=%0b expected 1 %0d %0b",
                 k, out_valid, out_data, out_last, e[k], k == 3);
      end
      tick();
    end
    checks++;
    if (in_ready !== 1'b1 || fill_level !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL asc_return: rdy=%0b fill=%0d vld=%0b expected 1 0 0", in_ready, fill_level, out_valid);
    end
    $display("test_ascending done");
  endtask

  task automatic test_descending();
    int v [4] = '{38, 29, 10, 55};
    int e [4] = '{55, 38, 29, 10};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = W'(v[i]);
      inv = (i == 0);
      tick();
    end
    in_valid = 1'b0;
    inv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(e[k]) || out_last !== (k == 3)) begin
        errors++;
        $display("FAIL desc_out[%0d]: vld=%0b data=%0d last=%0b expected 1 %0d %0b",
                 k, out_valid, out_data, out_last, e[k], k == 3);
      end
      tick();
    end
    $display("test_descending done");
  endtask

  task automatic test_early_close();
    int v [3] = '{25, 40, 7};
    int e [3] = '{7, 25, 40};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    inv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = W'(v[i]);
      in_last = (i == 2);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(e[k]) || out_last !== (k == 2) || fill_level !== 3'd3) begin
        errors++;
        $display("FAIL early_out[%0d]: vld=%0b data=%0d last=%0b fill=%0d expected 1 %0d %0b 3",
                 k, out_valid, out_data, out_last, fill_level, e[k], k == 2);
      end
      tick();
    end
    $display("test_early_close done");
  endtask

  task automatic test_duplicates();
    int v [4] = '{63, 0, 63, 0};
    int e [4] = '{0, 0, 63, 63};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    inv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = W'(v[i]);
      tick();
    end
    in_data = 6'd1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_data !== W'(e[k]) || out_last !== (k == 3) || in_ready !== 1'b0 || fill_level !== 3'd4) begin
        errors++;
        $display("FAIL dup_out[%0d]: data=%0d last=%0b rdy=%0b fill=%0d expected %0d %0b 0 4",
                 k, out_data, out_last, in_ready, fill_level, e[k], k == 3);
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (fill_level !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL dup_return: fill=%0d rdy=%0b expected 0 1", fill_level, in_ready);
    end
    $display("test_duplicates done");
  endtask

  task automatic test_backpressure();
    int v [4] = '{13, 22, 33, 59};
    int e [4] = '{13, 22, 33, 59};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    inv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = W'(v[i]);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          checks++;
          if (out_valid !== 1'b1 || out_data !== 6'd33 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: vld=%0b data=%0d last=%0b expected 1 33 0",
                     s, out_valid, out_data, out_last);
          end
          tick();
        end
        out_ready = 1'b1;
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(e[k]) || out_last !== (k == 3)) begin
        errors++;
        $display("FAIL bp_out[%0d]: vld=%0b data=%0d last=%0b expected 1 %0d %0b",
                 k, out_valid, out_data, out_last, e[k], k == 3);
      end
      tick();
    end
    $display("test_backpressure done");
  endtask

  task automatic test_reset_mid_drain();
    int v [4] = '{9, 1, 4, 2};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    inv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = W'(v[i]);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_data !== 6'd1) begin
      errors++;
      $display("FAIL rst_first_out: got %0d expected 1", out_data);
    end
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_data, out_last, fill_level} !== {1'b1, 1'b0, 6'd0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL rst_mid_drain: rdy=%0b vld=%0b data=%0d last=%0b fill=%0d expected 1 0 0 0 0",
               in_ready, out_valid, out_data, out_last, fill_level);
    end
    tick();
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1;
    in_data = 6'd5;
    tick();
    in_data = 6'd3;
    in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== ((k == 0) ? 6'd3 : 6'd5) || out_last !== (k == 1)) begin
        errors++;
        $display("FAIL post_rst_out[%0d]: vld=%0b data=%0d last=%0b expected 1 %0d %0b",
                 k, out_valid, out_data, out_last, (k == 0) ? 3 : 5, k == 1);
      end
      tick();
    end
    $display("test_reset_mid_drain done");
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_descending();
    test_early_close();
    test_duplicates();
    test_backpressure();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
